// File: rtl/msfsm_sync_array.sv
// msfsm_sync_array: serially configured array of table-driven state machines
// that synchronise on a shared alphabet of input and output events.
module msfsm_sync_array #(
    parameter int N_FSM    = 2,
    parameter int N_STATES = 8,
    parameter int N_IN     = 4,
    parameter int N_OUT    = 2,
    localparam int SW      = (N_STATES > 1) ? $clog2(N_STATES) : 1,
    localparam int N_EV    = N_IN + N_OUT,
    localparam int EW      = (N_EV > 1) ? $clog2(N_EV) : 1,
    localparam int MW      = N_FSM * N_EV,
    localparam int CW      = MW + N_FSM * N_STATES * N_EV * (SW + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_en,
    input  logic                  cfg_data,
    input  logic [N_IN-1:0]       in_evt,
    output logic [N_OUT-1:0]      out_evt,
    output logic                  err,
    output logic [N_FSM*SW-1:0]   state
);
    logic [CW-1:0]                       cfg_q;
    logic [N_FSM-1:0][SW-1:0]            st_q, st_d;
    logic [N_OUT-1:0]                    out_q, out_d;
    logic                                err_q, err_d;
    logic [N_FSM-1:0][N_EV-1:0]          msk, vld;
    logic [N_FSM-1:0][N_EV-1:0][SW-1:0]  nxt;
    logic [N_EV-1:0]                     in_alpha, allow, en;
    logic                                take, multi;
    logic [EW-1:0]                       sel;

    assign msk = cfg_q[MW-1:0];

    // A state outside the table matches no row, so it reads as "nothing valid".
    always_comb begin
        vld = '0;
        nxt = '0;
        for (int f = 0; f < N_FSM; f++)
            for (int s = 0; s < N_STATES; s++)
                if (st_q[f] == SW'(s))
                    for (int e = 0; e < N_EV; e++) begin
                        vld[f][e] = cfg_q[MW + ((f*N_STATES+s)*N_EV+e)*(SW+1)];
                        nxt[f][e] = cfg_q[MW + ((f*N_STATES+s)*N_EV+e)*(SW+1) + 1 +: SW];
                    end
    end

    always_comb begin
        in_alpha = '0;
        allow    = '1;
        for (int f = 0; f < N_FSM; f++)
            for (int e = 0; e < N_EV; e++) begin
                in_alpha[e] = in_alpha[e] | msk[f][e];
                allow[e]    = allow[e] & (~msk[f][e] | vld[f][e]);
            end
    end

    assign en    = in_alpha & allow;
    assign multi = |(in_evt & (in_evt - N_IN'(1)));

    // Inputs win over outputs; among outputs the lowest index fires.
    always_comb begin
        take  = 1'b0;
        sel   = '0;
        out_d = '0;
        err_d = err_q;
        if (|in_evt) begin
            for (int i = 0; i < N_IN; i++)
                if (in_evt[i]) sel = EW'(i);
            take  = !multi && en[sel];
            err_d = err_q | !take;
        end else begin
            for (int o = N_OUT - 1; o >= 0; o--)
                if (en[N_IN+o]) begin
                    take     = 1'b1;
                    sel      = EW'(N_IN + o);
                    out_d    = '0;
                    out_d[o] = 1'b1;
                end
        end
    end

    always_comb
        for (int f = 0; f < N_FSM; f++)
            st_d[f] = (take && msk[f][sel]) ? nxt[f][sel] : st_q[f];

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cfg_q <= '0;
            st_q  <= '0;
            out_q <= '0;
            err_q <= 1'b0;
        end else if (cfg_en) begin
            cfg_q <= {cfg_data, cfg_q[CW-1:1]};
            st_q  <= '0;
            out_q <= '0;
        end else begin
            st_q  <= st_d;
            out_q <= out_d;
            err_q <= err_d;
        end

    assign out_evt = out_q;
    assign err     = err_q;
    assign state   = st_q;
endmodule

// File: tb/tb_msfsm_sync_array.sv
// tb_msfsm_sync_array: directed scenarios for the synchronised FSM array,
// checked by a monitor against a queue of per-cycle expectations.
module tb_msfsm_sync_array;
    localparam int CW = 396;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_en = 1'b0;
    logic       cfg_data = 1'b0;
    logic [3:0] in_evt = '0;
    logic [1:0] out_evt;
    logic       err;
    logic [5:0] state;

    msfsm_sync_array dut (
        .clk(clk), .reset(reset), .cfg_en(cfg_en), .cfg_data(cfg_data),
        .in_evt(in_evt), .out_evt(out_evt), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] o;
        logic [5:0] s;
        logic       e;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [CW-1:0] cfg_v = '0;

    function automatic logic [5:0] st(input logic [2:0] f0, input logic [2:0] f1);
        return {f1, f0};
    endfunction

    task automatic push(input string name, input logic [1:0] o, input logic [5:0] s, input logic e);
        exp_t x;
        x.name = name;
        x.o = o;
        x.s = s;
        x.e = e;
        q.push_back(x);
    endtask

    task automatic step(input string name, input logic [3:0] ev, input logic [1:0] o, input logic [5:0] s, input logic e);
        @(negedge clk);
        cfg_en = 1'b0;
        in_evt = ev;
        push(name, o, s, e);
    endtask

    task automatic rst_pulse(input string name);
        @(negedge clk);
        reset  = 1'b1;
        cfg_en = 1'b0;
        in_evt = '0;
        push(name, 2'b00, 6'o00, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load(input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            cfg_en   = 1'b1;
            cfg_data = cfg_v[i];
            in_evt   = '0;
        end
    endtask

    task automatic set_ent(input int f, input int s, input int e, input int n);
        cfg_v[12 + ((f*8+s)*6+e)*4 +: 4] = {3'(n), 1'b1};
    endtask

    task automatic scen2(input string tag);
        step({tag, "a+"},   4'b0001, 2'b00, st(1, 0), 1'b0);
        step({tag, "b+"},   4'b0100, 2'b00, st(1, 1), 1'b0);
        step({tag, "out+"}, 4'b0000, 2'b01, st(2, 2), 1'b0);
        step({tag, "idle"}, 4'b0000, 2'b00, st(2, 2), 1'b0);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                n_chk++;
                if (out_evt !== x.o || state !== x.s || err !== x.e) begin
                    n_fail++;
                    $display("FAIL %s: got out_evt=%b state=%o err=%b, expected out_evt=%b state=%o err=%b",
                             x.name, out_evt, state, err, x.o, x.s, x.e);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // FSMk tracks input k (a or b) and the output: s0 x=0,o=0; s1 x=1,o=0; s2 x=1,o=1; s3 x=0,o=1.
        for (int f = 0; f < 2; f++) begin
            cfg_v[f*6 + 2*f]     = 1'b1;
            cfg_v[f*6 + 2*f + 1] = 1'b1;
            cfg_v[f*6 + 4]       = 1'b1;
            cfg_v[f*6 + 5]       = 1'b1;
            set_ent(f, 0, 2*f, 1);
            set_ent(f, 1, 2*f + 1, 0);
            set_ent(f, 1, 4, 2);
            set_ent(f, 2, 2*f + 1, 3);
            set_ent(f, 3, 5, 0);
        end
        set_ent(1, 2, 5, 1);

        rst_pulse("reset");
        step("nocfg_a+",   4'b0001, 2'b00, 6'o00, 1'b1);
        step("nocfg_idle", 4'b0000, 2'b00, 6'o00, 1'b1);

        rst_pulse("reset2");
        load(CW);
        scen2("s2_");
        step("s3_a-",    4'b0010, 2'b00, st(3, 2), 1'b0);
        step("s3_out-",  4'b0000, 2'b10, st(0, 1), 1'b0);
        step("s3_a-bad", 4'b0010, 2'b00, st(0, 1), 1'b1);
        step("s3_idle",  4'b0000, 2'b00, st(0, 1), 1'b1);

        rst_pulse("reset3");
        load(100);
        rst_pulse("reset_midshift");
        step("partial_idle", 4'b0000, 2'b00, 6'o00, 1'b0);
        step("partial_a+",   4'b0001, 2'b00, 6'o00, 1'b1);

        rst_pulse("reset4");
        load(CW);
        scen2("rerun_");
        step("s4_multi",   4'b0101, 2'b00, st(2, 2), 1'b1);
        step("s5_a-",      4'b0010, 2'b00, st(3, 2), 1'b1);
        step("s5_b_prio",  4'b1000, 2'b00, st(3, 3), 1'b1);
        step("s5_out-",    4'b0000, 2'b10, st(0, 0), 1'b1);
        step("s5_idle",    4'b0000, 2'b00, st(0, 0), 1'b1);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
